adc_volt_conv: RTL and testbench

ADC_VOLT_CONV -- requirements
Module: adc_volt_conv

---
 rtl/adc_volt_conv.sv | 166 ++++++++++++++++
 tb/tb_adc_volt_conv.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_volt_conv.sv
// Multi-channel ADC code to millivolt converter with selectable power-of-two
// averaging window; three-stage pipeline: code/over-range, accumulate, scale.
module adc_volt_conv #(
    parameter int ADC_W    = 12,
    parameter int NCH      = 2,
    parameter int MV_SCALE = 20000,
    parameter int MV_SHIFT = 13
) (
    input  logic                 ad_clk,
    input  logic                 sys_rst,
    input  logic [NCH*ADC_W-1:0] ad_in,
    input  logic                 in_valid,
    input  logic [1:0]           avg_sel,
    output logic [NCH*16-1:0]    volt_out,
    output logic [NCH-1:0]       ovr,
    output logic                 out_valid
);
    localparam int CW = ADC_W + 1;
    localparam int AW = ADC_W + 4;
    localparam int PW = AW + 16;
    localparam logic [ADC_W-1:0] MID = {1'b1, {(ADC_W-1){1'b0}}};

    logic [2:0]                 r_cnt;
    logic [1:0]                 r_win_sel;
    logic [1:0]                 w_win_sel;
    logic [2:0]                 w_last_cnt;
    logic                       w_close;

    logic                       r_s1_valid;
    logic                       r_s1_close;
    logic [1:0]                 r_s1_shift;
    logic signed [CW-1:0]       r_s1_code [NCH];
    logic [NCH-1:0]             r_s1_ovr;

    logic signed [AW-1:0]       r_acc      [NCH];
    logic signed [AW-1:0]       w_acc_next [NCH];
    logic [NCH-1:0]             r_sticky;
    logic [NCH-1:0]             w_sticky_next;
    logic                       r_s2_valid;
    logic signed [AW-1:0]       r_s2_sum   [NCH];
    logic [NCH-1:0]             r_s2_ovr;
    logic [1:0]                 r_s2_shift;

    logic [NCH-1:0][15:0]       w_mv;
    logic [NCH-1:0][15:0]       r_volt;
    logic [NCH-1:0]             r_ovr;
    logic                       r_out_valid;

    // Window bookkeeping sits at the input so avg_sel is sampled alongside
    // the first sample of a window and the close mark travels with the data.
    // NOTE: every path assigns each output, so no latch can be inferred.
    always_comb begin
        w_win_sel = (r_cnt == 3'd0) ? avg_sel : r_win_sel;
        case (w_win_sel)
            2'd0:    w_last_cnt = 3'd0;
            2'd1:    w_last_cnt = 3'd1;
            2'd2:    w_last_cnt = 3'd3;
            default: w_last_cnt = 3'd7;
        endcase
        w_close = (r_cnt == w_last_cnt);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together on the edge regardless of statement order.
    always_ff @(posedge ad_clk) begin
        if (sys_rst) begin
            r_cnt      <= '0;
            r_win_sel  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_close <= 1'b0;
            r_s1_shift <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_cnt      <= w_close ? 3'd0 : r_cnt + 3'd1;
                r_win_sel  <= w_win_sel;
                r_s1_close <= w_close;
                r_s1_shift <= w_win_sel;
            end
        end
    end

    // NOTE: data-only registers skip reset; the valid bits qualify them.
    always_ff @(posedge ad_clk) begin
        if (in_valid) begin
            for (int k = 0; k < NCH; k++) begin
                r_s1_code[k] <= $signed({1'b0, ad_in[k*ADC_W +: ADC_W]}) - $signed({1'b0, MID});
                r_s1_ovr[k]  <= (ad_in[k*ADC_W +: ADC_W] == '0) || (ad_in[k*ADC_W +: ADC_W] == '1);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            w_acc_next[k] = r_acc[k] + {{(AW-CW){r_s1_code[k][CW-1]}}, r_s1_code[k]};
        end
        w_sticky_next = r_sticky | r_s1_ovr;
    end

    // The closing sample is folded into the registered sum while the
    // accumulator restarts from zero in the same cycle.
    always_ff @(posedge ad_clk) begin
        if (sys_rst) begin
            for (int k = 0; k < NCH; k++) begin
                r_acc[k]    <= '0;
                r_s2_sum[k] <= '0;
            end
            r_sticky   <= '0;
            r_s2_ovr   <= '0;
            r_s2_shift <= '0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid && r_s1_close;
            if (r_s1_valid) begin
                if (r_s1_close) begin
                    for (int k = 0; k < NCH; k++) begin
                        r_s2_sum[k] <= w_acc_next[k];
                        r_acc[k]    <= '0;
                    end
                    r_s2_ovr   <= w_sticky_next;
                    r_s2_shift <= r_s1_shift;
                    r_sticky   <= '0;
                end else begin
                    for (int k = 0; k < NCH; k++) begin
                        r_acc[k] <= w_acc_next[k];
                    end
                    r_sticky <= w_sticky_next;
                end
            end
        end
    end

    // Scale the magnitude so truncation is toward zero, then restore the sign.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic          w_neg;
        logic [AW-1:0] w_abs;
        logic [PW-1:0] w_prod;
        logic [PW-1:0] w_mag;

        assign w_neg   = r_s2_sum[k][AW-1];
        assign w_abs   = w_neg ? AW'(-r_s2_sum[k]) : AW'(r_s2_sum[k]);
        assign w_prod  = PW'(w_abs) * PW'(MV_SCALE);
        assign w_mag   = w_prod >> (MV_SHIFT + int'(r_s2_shift));
        assign w_mv[k] = w_neg ? ((w_mag > PW'(32768)) ? 16'h8000 : 16'(-w_mag))
                               : ((w_mag > PW'(32767)) ? 16'h7FFF : w_mag[15:0]);
    end

    always_ff @(posedge ad_clk) begin
        if (sys_rst) begin
            r_volt      <= '0;
            r_ovr       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_volt <= w_mv;
                r_ovr  <= r_s2_ovr;
            end
        end
    end

    assign volt_out  = r_volt;
    assign ovr       = r_ovr;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_adc_volt_conv.sv
// Bench for adc_volt_conv: constant vectors, directed window/reset sequences,
// and random traffic checked every cycle against a window-level model.
module tb_adc_volt_conv;
    localparam int ADC_W    = 12;
    localparam int NCH      = 2;
    localparam int MV_SCALE = 20000;
    localparam int MV_SHIFT = 13;

    logic                 ad_clk = 1'b0;
    logic                 sys_rst;
    logic [NCH*ADC_W-1:0] ad_in;
    logic                 in_valid;
    logic [1:0]           avg_sel;
    logic [NCH*16-1:0]    volt_out;
    logic [NCH-1:0]       ovr;
    logic                 out_valid;

    always #5 ad_clk = ~ad_clk;

    adc_volt_conv #(
        .ADC_W    (ADC_W),
        .NCH      (NCH),
        .MV_SCALE (MV_SCALE),
        .MV_SHIFT (MV_SHIFT)
    ) dut (
        .ad_clk    (ad_clk),
        .sys_rst   (sys_rst),
        .ad_in     (ad_in),
        .in_valid  (in_valid),
        .avg_sel   (avg_sel),
        .volt_out  (volt_out),
        .ovr       (ovr),
        .out_valid (out_valid)
    );

    typedef struct {
        int          due;
        logic [31:0] volt;
        logic [1:0]  ovr;
    } exp_t;

    typedef struct {
        logic [11:0] code;
        logic [15:0] mv;
        logic        ovr;
    } vec_t;

    int          n_tests      = 0;
    int          n_fail       = 0;
    int          edge_n       = 0;
    int          ov_count     = 0;
    int          last_ov_edge = -1;
    exp_t        exp_q[$];
    logic [23:0] win_q[$];
    int          win_len      = 1;
    int          win_sel_m    = 0;
    logic [31:0] mdl_volt     = '0;
    logic [1:0]  mdl_ovr      = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
                     name, got, got, exp, exp, edge_n);
        end
    endtask

    function automatic logic [15:0] mv_of(input longint sum, input int sel);
        longint mag;
        longint mv;
        mag = (sum < 0) ? -sum : sum;
        mag = (mag * MV_SCALE) >> (MV_SHIFT + sel);
        mv  = (sum < 0) ? -mag : mag;
        if (mv > 32767)  mv = 32767;
        if (mv < -32768) mv = -32768;
        return mv[15:0];
    endfunction

    function automatic int code_of(input logic [23:0] d, input int ch);
        logic [23:0] t;
        t = d >> (ch * ADC_W);
        return int'(t[11:0]);
    endfunction

    // Window-level reference: collect whole windows of samples, then sum them.
    task automatic model_step(input logic v, input logic [1:0] s, input logic [23:0] d, input logic r);
        exp_t e;
        longint sum;
        logic flag;
        int c;
        if (r) begin
            win_q.delete();
            exp_q.delete();
            mdl_volt = '0;
            mdl_ovr  = '0;
        end else if (v) begin
            if (win_q.size() == 0) begin
                win_len   = 1 << int'(s);
                win_sel_m = int'(s);
            end
            win_q.push_back(d);
            if (win_q.size() == win_len) begin
                e.due  = edge_n + 2;
                e.volt = '0;
                e.ovr  = '0;
                for (int ch = 0; ch < NCH; ch++) begin
                    sum  = 0;
                    flag = 1'b0;
                    foreach (win_q[i]) begin
                        c    = code_of(win_q[i], ch);
                        sum += longint'(c - 2048);
                        if (c == 0 || c == 4095) flag = 1'b1;
                    end
                    e.volt[ch*16 +: 16] = mv_of(sum, win_sel_m);
                    e.ovr[ch]           = flag;
                end
                exp_q.push_back(e);
                win_q.delete();
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [1:0] s, input logic [23:0] d, input logic r);
        logic exp_v;
        in_valid = v;
        avg_sel  = s;
        ad_in    = d;
        sys_rst  = r;
        @(posedge ad_clk);
        edge_n++;
        model_step(v, s, d, r);
        #1;
        exp_v = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
            exp_v    = 1'b1;
            mdl_volt = exp_q[0].volt;
            mdl_ovr  = exp_q[0].ovr;
            void'(exp_q.pop_front());
        end
        check("out_valid", 64'(out_valid), 64'(exp_v));
        check("volt_out", 64'(volt_out), 64'(mdl_volt));
        check("ovr", 64'(ovr), 64'(mdl_ovr));
        if (out_valid === 1'b1) begin
            ov_count++;
            last_ov_edge = edge_n;
        end
    endtask

    task automatic send(input logic [23:0] d, input logic [1:0] s);
        cyc(1'b1, s, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 24'h0, 1'b0);
    endtask

    vec_t tbl[5];

    initial begin
        int          j;
        int          n;
        int          ov0;
        logic [23:0] d;
        logic        v;
        logic        r;
        logic [1:0]  s;

        tbl[0] = '{12'h800, 16'd0,        1'b0};
        tbl[1] = '{12'h801, 16'd2,        1'b0};
        tbl[2] = '{12'h7FF, 16'(-2),      1'b0};
        tbl[3] = '{12'hFFF, 16'd4997,     1'b1};
        tbl[4] = '{12'h000, 16'(-5000),   1'b1};

        for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 24'h0, 1'b1);
        check("rst_volt", 64'(volt_out), 64'd0);

        // Single-sample conversions, one table entry per channel.
        for (int i = 0; i < 5; i++) begin
            j = (i + 2) % 5;
            send({tbl[j].code, tbl[i].code}, 2'd0);
            n = edge_n;
            idle(3);
            check("t34_latency", 64'(last_ov_edge), 64'(n + 2));
            check("t34_ch0", 64'(volt_out[15:0]), 64'(tbl[i].mv));
            check("t34_ch1", 64'(volt_out[31:16]), 64'(tbl[j].mv));
            check("t34_ovr", 64'(ovr), 64'({tbl[j].ovr, tbl[i].ovr}));
        end

        // Four-sample window.
        ov0 = ov_count;
        send({12'h800, 12'h800}, 2'd2);
        send({12'h800, 12'h801}, 2'd2);
        send({12'h800, 12'h802}, 2'd2);
        send({12'h800, 12'h803}, 2'd2);
        n = edge_n;
        idle(4);
        check("t35_count", 64'(ov_count - ov0), 64'd1);
        check("t35_latency", 64'(last_ov_edge), 64'(n + 2));
        check("t35_ch0", 64'(volt_out[15:0]), 64'd3);

        // Sticky over-range across a two-sample window.
        send({12'h800, 12'hFFF}, 2'd1);
        send({12'h800, 12'h900}, 2'd1);
        idle(4);
        check("t36_ch0", 64'(volt_out[15:0]), 64'd2811);
        check("t36_ovr", 64'(ovr), 64'b01);

        // avg_sel change inside an open window.
        ov0 = ov_count;
        send({12'h800, 12'h810}, 2'd2);
        send({12'h800, 12'h810}, 2'd2);
        send({12'h800, 12'h810}, 2'd0);
        send({12'h800, 12'h810}, 2'd0);
        send({12'h800, 12'h801}, 2'd0);
        idle(1);
        check("t37_first_valid", 64'(out_valid), 64'd1);
        check("t37_first_ch0", 64'(volt_out[15:0]), 64'd39);
        idle(1);
        check("t37_second_valid", 64'(out_valid), 64'd1);
        check("t37_second_ch0", 64'(volt_out[15:0]), 64'd2);
        idle(3);
        check("t37_count", 64'(ov_count - ov0), 64'd2);

        // Reset drops a partial window, including an in_valid during reset.
        send({12'h800, 12'hFFF}, 2'd3);
        send({12'h800, 12'hFFF}, 2'd3);
        send({12'h800, 12'hFFF}, 2'd3);
        cyc(1'b1, 2'd3, {12'hFFF, 12'hFFF}, 1'b1);
        check("t38_rst_volt", 64'(volt_out), 64'd0);
        check("t38_rst_ovr", 64'(ovr), 64'd0);
        check("t38_rst_valid", 64'(out_valid), 64'd0);
        ov0 = ov_count;
        for (int i = 0; i < 8; i++) send({12'h800, 12'h800}, 2'd3);
        n = edge_n;
        idle(4);
        check("t38_count", 64'(ov_count - ov0), 64'd1);
        check("t38_latency", 64'(last_ov_edge), 64'(n + 2));
        check("t38_volt", 64'(volt_out), 64'd0);
        check("t38_ovr", 64'(ovr), 64'd0);

        // Gapped strobe: invalid cycles carry junk that must be ignored.
        ov0 = ov_count;
        send({12'h800, 12'h900}, 2'd1);
        cyc(1'b0, 2'd3, 24'hFFFFFF, 1'b0);
        cyc(1'b0, 2'd3, 24'h000000, 1'b0);
        send({12'h800, 12'h880}, 2'd3);
        n = edge_n;
        idle(4);
        check("t39_count", 64'(ov_count - ov0), 64'd1);
        check("t39_latency", 64'(last_ov_edge), 64'(n + 2));
        check("t39_ch0", 64'(volt_out[15:0]), 64'd468);
        check("t39_ovr", 64'(ovr), 64'd0);

        // Back-to-back single-sample windows.
        ov0 = ov_count;
        for (int i = 0; i < 10; i++) send(24'($urandom), 2'd0);
        idle(3);
        check("b2b_count", 64'(ov_count - ov0), 64'd10);

        // Random traffic with occasional extremes and resets.
        for (int i = 0; i < 3000; i++) begin
            d = 24'($urandom);
            if ($urandom_range(0, 7) == 0) d[11:0]  = ($urandom_range(0, 1) != 0) ? 12'hFFF : 12'h000;
            if ($urandom_range(0, 7) == 0) d[23:12] = ($urandom_range(0, 1) != 0) ? 12'hFFF : 12'h000;
            v = ($urandom_range(0, 3) != 0);
            s = 2'($urandom_range(0, 3));
            r = ($urandom_range(0, 299) == 0);
            cyc(v, s, d, r);
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
